signext_arbiter: RTL and testbench
==================================

// Module: signext_arbiter
//
// PURPOSE
//   Shares one combinational signext unit (n-bit in, n+num-bit out, en-gated)
//   between two requesters (e.g. decode immediate path and branch-offset path).
//   Arbitrates, drives the shared unit for one cycle, registers the widened
//   result and returns it over a valid/ready response port tagged with the
//   winner's id. Sits between the requesters and the signext instance.
//
// PARAMETERS
//   N    8  input width of shared signext (its n)
//   NUM  4  extension bits added by signext (its num); result width N+NUM
//
// PORTS
//   clk         in   1        clock, all state updates on posedge
//   rst         in   1        synchronous, active-low reset
//   req_valid   in   2        per-requester request; bit i = requester i
//   req_data0   in   N        requester 0 operand, held while req_valid[0]
//   req_data1   in   N        requester 1 operand, held while req_valid[1]
//   req_ready   out  2        one-hot accept pulse; request taken this cycle
//   se_in       out  N        registered operand to shared signext .in
//   se_en       out  1        enable to shared signext .en
//   se_out      in   N+NUM    shared signext .out (combinational)
//   resp_valid  out  1        response available
//   resp_ready  in   1        consumer accepts response
//   resp_id     out  1        requester that owns resp_data
//   resp_data   out  N+NUM    registered sign-extended result
//   busy        out  1        high in EXTEND or RESP
//
// BEHAVIOUR
//   - Reset (rst==0 at posedge): state=IDLE, se_in=0, se_en=0, resp_valid=0,
//     resp_id=0, resp_data=0, req_ready=0, busy=0, RR pointer=0. Overrides
//     all other events; an in-flight transaction is dropped, no response.
//   - FSM IDLE -> EXTEND -> RESP -> IDLE.
//   - IDLE: if req_valid!=0, pick grant g (see CONFIGURATION); req_ready[g]=1
//     combinationally this cycle; at posedge se_in<=req_data_g, id<=g, ->EXTEND.
//     req_valid==0: stay, req_ready=0.
//   - EXTEND: se_en=1 for exactly one cycle; at posedge resp_data<=se_out,
//     resp_id<=id, resp_valid<=1, ->RESP. se_en=0 in all other states.
//   - RESP: resp_valid=1; resp_data/resp_id stable. resp_ready=1 -> at posedge
//     resp_valid<=0, ->IDLE. resp_ready=0 -> hold indefinitely.
//   - req_ready only ever asserted in IDLE, at most one bit set.
//   - Latency: accept at cycle T, resp_valid at T+2. Peak throughput one
//     result per 3 cycles; no bypass from RESP to accept.
//   - Requester dropping req_valid before grant: legal, nothing accepted.
//   - resp_ready and new req_valid together in RESP: retire response, new
//     request considered in the following IDLE cycle.
//   - resp_data is exactly se_out; no re-extension or truncation here.
//
// CONFIGURATION
//   SIGNEXT_ARB_RR_EN
//   - Undefined: fixed priority, requester 0 wins whenever req_valid[0]=1.
//   - Defined: round robin; 1-bit pointer p, grant p on tie, else sole
//     requester; on each grant g, p<=~g. Pointer reset to 0.
//
// TESTING
//   1. rst=0 two cycles, req_valid=2'b11 -> all outputs 0, req_ready=0.
//   2. req0 data 8'h85 alone -> req_ready=2'b01 at T, se_en=1 at T+1,
//      se_in=8'h85; resp_valid at T+2, resp_data=12'hF85, resp_id=0.
//   3. req1 data 8'h7F alone -> resp_data=12'h07F, resp_id=1, latency 2.
//   4. req_valid=2'b11 held, resp_ready=1 -> grants 0,0,0,0 without macro;
//      0,1,0,1 with SIGNEXT_ARB_RR_EN; one grant per 3 cycles.
//   5. resp_ready=0 for 5 cycles in RESP -> resp_valid, data, id stable,
//      req_ready=0 throughout; resp_ready=1 -> IDLE next cycle.
//   6. rst=0 during EXTEND -> IDLE next cycle, resp_valid never asserts,
//      pending requester re-accepted after rst returns to 1.

Source files
------------

// File: rtl/signext_arbiter.sv
// signext_arbiter: shares one combinational sign-extension unit between two
// requesters. A request is accepted in IDLE, its operand is presented to the
// shared unit for one EXTEND cycle, and the widened result is held in RESP
// until the consumer takes it.
//
// Optional feature macro: SIGNEXT_ARB_RR_EN
//   undefined -> fixed priority, requester 0 wins whenever it is requesting
//   defined   -> round robin between the two requesters using a 1-bit pointer
module signext_arbiter #(
    parameter int N   = 8,
    parameter int NUM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [N-1:0]     req_data0,
    input  logic [N-1:0]     req_data1,
    output logic [1:0]       req_ready,
    output logic [N-1:0]     se_in,
    output logic             se_en,
    input  logic [N+NUM-1:0] se_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [N+NUM-1:0] resp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXTEND = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_next;
    logic   grant;    // requester that would win if a request is accepted now
    logic   accept;   // a request is taken at the coming edge
    logic   id;       // owner of the operand currently in flight

`ifdef SIGNEXT_ARB_RR_EN
    logic rr_ptr;     // requester favoured on a tie

    // Round robin: favoured requester on a tie, otherwise the sole requester.
    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11) begin
            grant = rr_ptr;
        end
    end

    // After each grant the other requester becomes favoured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        grant = ~req_valid[0];
    end
`endif

    // Next state and the combinational handshake/enable outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        req_ready  = 2'b00;
        se_en      = 1'b0;
        unique case (state)
            IDLE: begin
                // Reset low at this edge discards the transfer, so no accept
                // pulse is offered while it is asserted.
                if (rst && (req_valid != 2'b00)) begin
                    req_ready  = grant ? 2'b10 : 2'b01;
                    state_next = EXTEND;
                end
            end
            EXTEND: begin
                se_en      = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = (req_ready != 2'b00);
    assign busy   = (state != IDLE);

    // State register, operand capture and response registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!rst) begin
            state      <= IDLE;
            se_in      <= '0;
            id         <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                se_in <= grant ? req_data1 : req_data0;
                id    <= grant;
            end
            if (state == EXTEND) begin
                resp_data  <= se_out;
                resp_id    <= id;
                resp_valid <= 1'b1;
            end else if ((state == RESP) && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_signext_arbiter.sv
// Testbench for signext_arbiter: directed scenarios followed by randomized
// traffic. A monitor on the falling edge keeps a transaction-level model
// (grant choice, per-transaction age, expected result queue) and compares
// every DUT output against it. Honours SIGNEXT_ARB_RR_EN the same way the RTL does.
module tb_signext_arbiter;

    localparam int N   = 8;
    localparam int NUM = 4;
    localparam int W   = N + NUM;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [N-1:0] req_data0 = '0;
    logic [N-1:0] req_data1 = '0;
    logic [1:0]   req_ready;
    logic [N-1:0] se_in;
    logic         se_en;
    logic [W-1:0] se_out;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic         resp_id;
    logic [W-1:0] resp_data;
    logic         busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic         id;
        logic [N-1:0] data;
        logic [W-1:0] result;
    } txn_t;

    txn_t sb[$];

    signext_arbiter #(.N(N), .NUM(NUM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .se_in     (se_in),
        .se_en     (se_en),
        .se_out    (se_out),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .busy      (busy)
    );

    // Shared sign-extension unit sitting beside the arbiter.
    assign se_out = se_en ? {{NUM{se_in[N-1]}}, se_in} : '0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: the operand as a signed number, reduced modulo 2**W.
    function automatic logic [W-1:0] ext_ref(input logic [N-1:0] d);
        int v;
        v = (int'(d) >= (1 << (N - 1))) ? int'(d) - (1 << N) : int'(d);
        return W'(v);
    endfunction

    // Expected winner given the requests and the model's favoured requester.
    function automatic logic pick(input logic [1:0] v, input logic fav);
`ifdef SIGNEXT_ARB_RR_EN
        if (v == 2'b11) return fav;
        return v[1];
`else
        return v[0] ? 1'b0 : 1'b1;
`endif
    endfunction

    // ---------------- monitor / reference model ----------------
    logic rst_q = 1'b0;       // reset value seen by the most recent edge
    logic outstanding = 1'b0; // a transaction has been accepted and not retired
    int   age = 0;            // edges since the outstanding transaction was accepted
    logic fav = 1'b0;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        logic       idle_now;
        logic       g;
        logic [1:0] exp_rdy;
        txn_t       t;
        if (!rst_q) begin
            outstanding = 1'b0;
            age = 0;
            fav = 1'b0;
            sb.delete();
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_se_en", 32'(se_en), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_resp_data", 32'(resp_data), 32'd0);
            check("rst_resp_id", 32'(resp_id), 32'd0);
            check("rst_se_in", 32'(se_in), 32'd0);
        end else begin
            if (outstanding) age++;
            check("busy", 32'(busy), 32'(outstanding));
            check("se_en", 32'(se_en), 32'(outstanding && age == 1));
            check("resp_valid", 32'(resp_valid), 32'(outstanding && age >= 2));
            if (outstanding && age == 1 && sb.size() > 0)
                check("se_in", 32'(se_in), 32'(sb[0].data));
        end
        idle_now = !outstanding;
        if (rst_q && resp_valid && sb.size() > 0) begin
            check("resp_data", 32'(resp_data), 32'(sb[0].result));
            check("resp_id", 32'(resp_id), 32'(sb[0].id));
            if (resp_ready) begin
                void'(sb.pop_front());
                outstanding = 1'b0;
            end
        end
        g = pick(req_valid, fav);
        exp_rdy = (idle_now && rst && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            t.id     = g;
            t.data   = g ? req_data1 : req_data0;
            t.result = ext_ref(t.data);
            sb.push_back(t);
            outstanding = 1'b1;
            age = 0;
            fav = ~g;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string name);
        int i;
        for (i = 0; i < 20 && !resp_valid; i++) tick();
        if (!resp_valid) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout waiting for resp_valid", name);
        end
    endtask

    task automatic drain();
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    logic grants[$];
    logic [1:0] acc;

    initial begin
        // 1: reset with both requesting
        rst = 1'b0;
        req_valid = 2'b11;
        req_data0 = 8'h12;
        req_data1 = 8'h34;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        check("rst_req_ready2", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        rst = 1'b1;
        tick();

        // 2: requester 0 alone, negative operand
        req_data0 = 8'h85;
        req_valid = 2'b01;
        #1 check("t2_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        check("t2_se_en", 32'(se_en), 32'd1);
        check("t2_se_in", 32'(se_in), 32'h85);
        tick();
        check("t2_lat", 32'(resp_valid), 32'd1);
        check("t2_data", 32'(resp_data), 32'hF85);
        check("t2_id", 32'(resp_id), 32'd0);
        drain();

        // 3: requester 1 alone, positive operand
        req_data1 = 8'h7F;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        check("t3_lat", 32'(resp_valid), 32'd1);
        check("t3_data", 32'(resp_data), 32'h07F);
        check("t3_id", 32'(resp_id), 32'd1);
        drain();

        // 4: both requesting continuously
        req_valid = 2'b11;
        resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req_ready != 2'b00) grants.push_back(req_ready[1]);
            tick();
        end
        check("t4_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef SIGNEXT_ARB_RR_EN
            check("t4_grant", 32'(grants[i]), 32'(i % 2));
`else
            check("t4_grant", 32'(grants[i]), 32'd0);
`endif
        end
        drain();

        // 5: consumer stalls for five cycles while both keep requesting
        req_data0 = 8'hC3;
        req_valid = 2'b01;
        resp_ready = 1'b0;
        tick();
        req_valid = 2'b11;
        wait_resp("t5_resp");
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_data", 32'(resp_data), 32'hFC3);
            check("t5_hold_rdy", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_reaccept", 32'(req_ready != 2'b00), 32'd1);
        req_valid = 2'b00;
        drain();

        // 6: reset while EXTEND is in progress
        req_data0 = 8'hA0;
        req_valid = 2'b01;
        tick();
        check("t6_extend", 32'(se_en), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_no_resp", 32'(resp_valid), 32'd0);
        check("t6_reaccept", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        drain();

        // Random traffic: requesters hold operands until accepted.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (req_valid[r] && acc[r]) begin
                    req_valid[r] = 1'($urandom_range(0, 1));
                    if (r == 0) req_data0 = N'($urandom);
                    else        req_data1 = N'($urandom);
                end else if (req_valid[r]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[r] = 1'b0;
                end else begin
                    req_valid[r] = 1'($urandom_range(0, 1));
                    if (r == 0) req_data0 = N'($urandom);
                    else        req_data1 = N'($urandom);
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) != 0);
        end
        rst = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
